mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles an access may wait for mem_ack (range 1-255).
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port fetch_request  in  1  core wants next instruction.
REQ-005 SHALL have port fetch_addr  in  32  instruction address.
REQ-006 SHALL have port memory_request  in  1  current instruction needs data access.
REQ-007 SHALL have port memory_request_type  in  1  0 = load, 1 = store.
REQ-008 SHALL have port memory_addr / write_data / write_mask  in  32/32/4  data access address, store data, byte mask.
REQ-009 SHALL have port stall  out  1  freezes core PC and register writes.
REQ-010 SHALL have port fetch_data_valid / memory_data_valid  out  1/1  single-cycle completion pulses.
REQ-011 SHALL have port request_data  out  32  read data returned to core (= mem_rdata).
REQ-012 SHALL have port mem_req / mem_we  out  1/1  external request and write enable.
REQ-013 SHALL have port mem_addr / mem_wdata / mem_wmask  out  32/32/4  external access fields.
REQ-014 SHALL have port mem_ack / mem_rdata  in  1/32  external completion; rdata valid in ack cycle.
REQ-015 SHALL have port bus_error  out  1  sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, DATA, FETCH; one outstanding external access max.
REQ-017 In IDLE: memory_request=1 and data_done=0 -> latch memory_addr/write_data/write_mask/type into mem_* regs, go DATA; else fetch_request=1 -> latch fetch_addr, mem_we=0, mem_wmask=0, go FETCH; else stay.
REQ-018 Data SHALL win over fetch when both are pending in IDLE (data belongs to current instruction).
REQ-019 mem_req SHALL be 1 exactly while state is DATA or FETCH; mem_* fields SHALL be held constant from the registers until ack.
REQ-020 DATA with mem_ack=1: memory_data_valid=1 that cycle (loads and stores), set data_done, go IDLE next edge.
REQ-021 FETCH with mem_ack=1: fetch_data_valid=1 that cycle, clear data_done, go IDLE next edge.
REQ-022 stall SHALL be combinational: 0 only when state=FETCH and mem_ack=1; 1 otherwise, so an instruction retires on the edge its successor is captured.
REQ-023 Minimum latency: non-memory instruction = 2 cycles (IDLE, FETCH with same-cycle ack); load/store = 4 cycles.
REQ-024 mem_ack seen in IDLE SHALL be ignored (no pulse, no state change).
REQ-025 8-bit wait counter SHALL be cleared on issue, increment each DATA/FETCH cycle without ack; mem_ack in the cycle the counter would reach TIMEOUT_CYCLES SHALL take priority over timeout.
REQ-026 Counter = TIMEOUT_CYCLES without ack: set bus_error (sticky), go IDLE, no valid pulse; data timeout sets data_done (access abandoned), fetch timeout leaves data_done unchanged (fetch reissued).
REQ-027 request_data SHALL equal mem_rdata at all times; consumers qualify with valid pulses.

Reset
REQ-028 Reset asserted SHALL force state=IDLE, data_done=0, counter=0, bus_error=0, mem_req=0, mem_addr/mem_wdata/mem_wmask/mem_we=0 without waiting for clk.
REQ-029 Outputs during reset: stall=1, both valid pulses 0; an in-flight access is dropped and its later mem_ack is ignored per REQ-024.
REQ-030 First issue SHALL occur on the first edge after reset deasserts.

Verification
REQ-031 ALU-only stream, mem_ack tied 1: fetch 0x200, 0x204 -> fetch_data_valid every 2nd cycle, stall low only in those cycles, mem_we=0.
REQ-032 Load at 0x1000, ack delay 3, rdata 0xDEADBEEF: DATA held 3 cycles, memory_data_valid pulse with request_data=0xDEADBEEF, then FETCH issues; only one data access per instruction.
REQ-033 Store, write_data=0x12345678, mask 4'b0011: mem_we=1, mem_wmask=0011, mem_wdata stable until ack, memory_data_valid pulse.
REQ-034 Simultaneous memory_request and fetch_request in IDLE: mem_addr=data address first, fetch second.
REQ-035 TIMEOUT_CYCLES=4, mem_ack held 0: after 4 DATA cycles bus_error=1, state IDLE, FETCH issued next; bus_error stays 1 until reset.
REQ-036 Reset asserted mid-FETCH between edges: mem_req drops same cycle, stall=1; stray mem_ack after release produces no valid pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between instruction fetch and data access,
// one outstanding access at a time, with a wait-cycle timeout that raises a sticky bus_error.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_request,
  input  logic [31:0] fetch_addr,
  input  logic        memory_request,
  input  logic        memory_request_type,
  input  logic [31:0] memory_addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  output logic        stall,
  output logic        fetch_data_valid,
  output logic        memory_data_valid,
  output logic [31:0] request_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);
  localparam logic [7:0] TIMEOUT = TIMEOUT_CYCLES[7:0];
  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;
  state_t      state_q, state_d;
  logic        data_done_q, data_done_d, bus_error_q, bus_error_d, we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        busy, timeout;
  assign busy    = state_q != IDLE;
  // An ack in the cycle the counter would reach the limit still completes the access.
  assign timeout = busy && !mem_ack && (cnt_q + 8'd1 == TIMEOUT);
  always_comb begin
    state_d     = state_q;
    data_done_d = data_done_q;
    bus_error_d = bus_error_q | timeout;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = busy ? cnt_q + 8'd1 : 8'd0;
    case (state_q)
      IDLE:
        if (memory_request && !data_done_q) begin
          state_d = DATA;
          addr_d  = memory_addr;
          wdata_d = write_data;
          wmask_d = write_mask;
          we_d    = memory_request_type;
        end else if (fetch_request) begin
          state_d = FETCH;
          addr_d  = fetch_addr;
          wmask_d = 4'd0;
          we_d    = 1'b0;
        end
      DATA:
        if (mem_ack || timeout) begin
          state_d     = IDLE;
          data_done_d = 1'b1;
        end
      FETCH:
        if (mem_ack) begin
          state_d     = IDLE;
          data_done_d = 1'b0;
        end else if (timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      data_done_q <= 1'b0;
      bus_error_q <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 8'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      data_done_q <= data_done_d;
      bus_error_q <= bus_error_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
    end
  assign mem_req           = busy;
  assign mem_we            = we_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = wdata_q;
  assign mem_wmask         = wmask_q;
  assign bus_error         = bus_error_q;
  assign request_data      = mem_rdata;
  assign fetch_data_valid  = state_q == FETCH && mem_ack;
  assign memory_data_valid = state_q == DATA && mem_ack;
  // The core retires an instruction exactly on the edge its successor is fetched.
  assign stall             = !fetch_data_valid;
endmodule
